// File: rtl/sdrc_wb_memtest.sv
// Wishbone memory tester: writes a pattern over a word range in bursts,
// reads it back in bursts, counts mismatches and flags ack timeouts.
module sdrc_wb_memtest #(
    parameter int BURST_LEN = 8,
    parameter int TMO_W     = 10
) (
    input  logic        wb_clk_i,
    input  logic        wb_resetn,
    input  logic        start,
    input  logic [24:0] cfg_base_addr,
    input  logic [15:0] cfg_len,
    input  logic [1:0]  cfg_pat,
    input  logic [31:0] cfg_seed,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [15:0] err_cnt,
    output logic [24:0] first_err_addr,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [24:0] wb_addr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic [2:0]  wb_cti_o,
    input  logic        wb_ack_i,
    input  logic [31:0] wb_dat_i
);

    typedef enum logic [2:0] {IDLE, WR, WR_GAP, RD, RD_GAP, FIN} state_t;

    localparam logic [3:0]       BEAT_LAST = 4'(BURST_LEN - 1);
    // Last count value before the limit; the stb cycle seeing it is the final one.
    localparam logic [TMO_W-1:0] TMO_LAST  = {{(TMO_W-1){1'b1}}, 1'b0};

    state_t            state_q, state_d;
    logic [24:0]       base_q, base_d;
    logic [15:0]       len_q, len_d;
    logic [1:0]        pat_q, pat_d;
    logic [31:0]       seed_q, seed_d;
    logic [15:0]       idx_q, idx_d;
    logic [3:0]        beat_q, beat_d;
    logic [31:0]       lfsr_q, lfsr_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [15:0]       err_cnt_q, err_cnt_d;
    logic [24:0]       first_err_q, first_err_d;
    logic              pass_q, pass_d;
    logic              timeout_q, timeout_d;

    logic [24:0]       cur_addr;
    logic [31:0]       exp_data;
    logic              in_burst;
    logic              last_beat;

    // Galois LFSR step for polynomial 0x80200003 (right-shifting form).
    function automatic logic [31:0] lfsr_next(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
    endfunction

    // An all-zero LFSR would lock up, so a zero seed starts from 1.
    function automatic logic [31:0] lfsr_seed(input logic [31:0] s);
        return (s == 32'd0) ? 32'd1 : s;
    endfunction

    // Current word address, its pattern data and burst framing.
    always_comb begin
        cur_addr  = base_q + {7'b0, idx_q, 2'b00};
        case (pat_q)
            2'd0:    exp_data = {7'b0, cur_addr};
            2'd1:    exp_data = ~{7'b0, cur_addr};
            2'd2:    exp_data = seed_q;
            default: exp_data = lfsr_q;
        endcase
        in_burst  = (state_q == WR) || (state_q == RD);
        last_beat = (beat_q == BEAT_LAST) || (idx_q + 16'd1 == len_q);
    end

    assign busy           = (state_q == WR) || (state_q == WR_GAP) ||
                            (state_q == RD) || (state_q == RD_GAP);
    assign done           = (state_q == FIN);
    assign pass           = pass_q;
    assign timeout        = timeout_q;
    assign err_cnt        = err_cnt_q;
    assign first_err_addr = first_err_q;
    assign wb_cyc_o       = in_burst;
    assign wb_stb_o       = in_burst;
    assign wb_we_o        = (state_q == WR);
    assign wb_addr_o      = in_burst ? cur_addr : 25'd0;
    assign wb_dat_o       = (state_q == WR) ? exp_data : 32'd0;
    assign wb_sel_o       = in_burst ? 4'hF : 4'h0;
    assign wb_cti_o       = in_burst ? (last_beat ? 3'b111 : 3'b010) : 3'b000;

    // Next-state and datapath updates for the test sequencer.
    always_comb begin
        // NOTE: every *_d gets its hold value first so no path leaves one unassigned (no latches).
        state_d     = state_q;
        base_d      = base_q;
        len_d       = len_q;
        pat_d       = pat_q;
        seed_d      = seed_q;
        idx_d       = idx_q;
        beat_d      = beat_q;
        lfsr_d      = lfsr_q;
        tmo_d       = tmo_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        pass_d      = pass_q;
        timeout_d   = timeout_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d      = cfg_base_addr & 25'h1FF_FFFC;
                    len_d       = cfg_len;
                    pat_d       = cfg_pat;
                    seed_d      = cfg_seed;
                    idx_d       = 16'd0;
                    beat_d      = 4'd0;
                    lfsr_d      = lfsr_seed(cfg_seed);
                    tmo_d       = '0;
                    err_cnt_d   = 16'd0;
                    first_err_d = 25'd0;
                    pass_d      = 1'b0;
                    timeout_d   = 1'b0;
                    state_d     = (cfg_len == 16'd0) ? FIN : WR;
                end
            end
            WR, RD: begin
                if (wb_ack_i) begin
                    idx_d  = idx_q + 16'd1;
                    lfsr_d = lfsr_next(lfsr_q);
                    tmo_d  = '0;
                    if ((state_q == RD) && (wb_dat_i != exp_data)) begin
                        if (err_cnt_q == 16'd0)
                            first_err_d = cur_addr;
                        if (err_cnt_q != 16'hFFFF)
                            err_cnt_d = err_cnt_q + 16'd1;
                    end
                    if (last_beat) begin
                        beat_d  = 4'd0;
                        state_d = (state_q == WR) ? WR_GAP : RD_GAP;
                    end else begin
                        beat_d = beat_q + 4'd1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    tmo_d     = tmo_q + TMO_W'(1);
                    timeout_d = 1'b1;
                    state_d   = FIN;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            WR_GAP: begin
                tmo_d = '0;
                if (idx_q == len_q) begin
                    idx_d   = 16'd0;
                    lfsr_d  = lfsr_seed(seed_q);
                    state_d = RD;
                end else begin
                    state_d = WR;
                end
            end
            RD_GAP: begin
                tmo_d   = '0;
                state_d = (idx_q == len_q) ? FIN : RD;
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The verdict is fixed on entry to FIN so it is valid while done pulses.
        if ((state_d == FIN) && (state_q != FIN))
            pass_d = (err_cnt_d == 16'd0) && !timeout_d;
    end

    // State register; asynchronous reset clears everything.
    always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
        if (!wb_resetn) begin
            state_q     <= IDLE;
            base_q      <= 25'd0;
            len_q       <= 16'd0;
            pat_q       <= 2'd0;
            seed_q      <= 32'd0;
            idx_q       <= 16'd0;
            beat_q      <= 4'd0;
            lfsr_q      <= 32'd0;
            tmo_q       <= '0;
            err_cnt_q   <= 16'd0;
            first_err_q <= 25'd0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            state_q     <= state_d;
            base_q      <= base_d;
            len_q       <= len_d;
            pat_q       <= pat_d;
            seed_q      <= seed_d;
            idx_q       <= idx_d;
            beat_q      <= beat_d;
            lfsr_q      <= lfsr_d;
            tmo_q       <= tmo_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            pass_q      <= pass_d;
            timeout_q   <= timeout_d;
        end
    end

endmodule
